mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator for the word-addressed data `memory` block in the write-back datapath. It accepts byte, halfword and word requests from the pipeline's MEM stage over a valid/ready handshake. It drives `MemRead`, `MemWrite`, `Address` and `WD` into the memory and returns sign- or zero-extended load data and an error flag. Sub-word stores use a read-modify-write sequence because the memory writes full words only.

## Interface
- `WIDTH`, 32: data width; only 32 is supported (four byte lanes).
- `DEPTH`, 16: memory word-address width; must match the attached memory.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request (high only in IDLE).
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in DEPTH+2: byte address; word address is `req_addr[DEPTH+1:2]`.
- `req_wdata` in WIDTH: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out WIDTH: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal-size request.
- `MemRead` out 1: memory read enable.
- `MemWrite` out 1: memory write enable.
- `Address` out DEPTH: memory word address.
- `WD` out WIDTH: memory write data.
- `RD` in WIDTH: memory read data; valid at the posedge following a cycle with `MemRead`=1.

## Operation
- Byte order is little-endian. Byte lane k = `addr[1:0]` occupies bits [8k+7:8k]. The half at `addr[1]`=h occupies [16h+15:16h].
- Alignment:
  - Half requires `addr[0]`=0.
  - Word requires `addr[1:0]`=00.
  - Violations and size 11 are errors.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: `req_ready`=1. On `req_valid` & `req_ready`, the unit latches we, size, unsigned, addr and wdata, then moves to:
  - error → RESP with `resp_err`=1 and no memory access;
  - load → RD;
  - store word → WR;
  - store byte or half → RMW_RD.
- RD: `MemRead`=1 and `Address`=word address. At the closing posedge, the unit captures `RD`, selects the lane, extends it per size and unsigned, and goes to RESP.
- WR: `MemWrite`=1 and `WD`=wdata. The memory writes at the closing posedge. Then → RESP.
- RMW_RD: `MemRead`=1. At the closing posedge, the unit captures `RD` and merges the store bytes into the addressed lane(s), leaving the other lanes unchanged. Then → RMW_WR.
- RMW_WR: `MemWrite`=1 and `WD`=merged word. Then → RESP.
- RESP: `resp_valid`=1 with `resp_rdata` and `resp_err` held stable. When `resp_ready`=1 at a posedge → IDLE.
- `MemRead` and `MemWrite` are never high together and are never high outside the listed states.
- `Address` and `WD` hold their last values when not used.

## Timing
- Reset: state IDLE. `MemRead`, `MemWrite`, `Address`, `WD`, `resp_valid`, `resp_rdata` and `resp_err` are all 0. `req_ready`=1 from the first cycle after `rst` deasserts.
- `rst` mid-operation aborts at that posedge:
  - any pending `MemWrite` is not issued;
  - an RMW caught in RMW_RD leaves memory unchanged;
  - the pending response is dropped.
- Latency from the accepting posedge to `resp_valid`:
  - word load or word store: 2 cycles (1 memory cycle, then RESP);
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Back-to-back throughput: one request per (latency + 1) cycles, because the unit returns to IDLE before accepting the next request.
- A stalled response (`resp_ready`=0) holds RESP indefinitely, with no memory activity and `req_ready`=0.
- Load data comes from the memory's negedge read inside the RD cycle, so the value reflects all writes completed at earlier posedges.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x0010 → `MemWrite` for 1 cycle with `Address`=0x0004. The following word load returns `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- Byte loads and extension: mem[4]=0x80FF7F01. Signed byte load at 0x0013 → 0xFFFFFF80. Unsigned byte load at 0x0013 → 0x00000080. Signed half load at 0x0010 → 0x00007F01.
- Byte store RMW: mem[4]=0x11223344, store byte 0xAA at 0x0011 → RD cycle, then WR cycle with `WD`=0x1122AA44. Response arrives 3 cycles after accept.
- Errors: half at 0x0011, word at 0x0012, size 11 → `resp_err`=1 and `resp_rdata`=0 one cycle later, with no `MemRead` or `MemWrite` pulse.
- Backpressure: hold `resp_ready`=0 for 5 cycles → `resp_valid` and data stay stable and `req_ready`=0. Release → IDLE on the next posedge.
- Reset mid-RMW: assert `rst` in RMW_RD → `MemWrite` never pulses, memory word unchanged, all outputs 0 and `req_ready`=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed memory: byte/half/word accesses with
// sign/zero extension on loads and read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [DEPTH+1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_rdata,
    output logic               resp_err,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [DEPTH-1:0]   Address,
    output logic [WIDTH-1:0]   WD,
    input  logic [WIDTH-1:0]   RD
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               bad_s;
    logic [1:0]         size_r;
    logic [1:0]         off_r;
    logic               uns_r;
    logic [15:0]        wdata_r;
    logic               req_ready_r;
    logic               resp_valid_r;
    logic [WIDTH-1:0]   resp_rdata_r;
    logic               resp_err_r;
    logic               mem_read_r;
    logic               mem_write_r;
    logic [DEPTH-1:0]   address_r;
    logic [WIDTH-1:0]   wd_r;

    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0] word,
                                                     input logic [1:0] size,
                                                     input logic [1:0] off,
                                                     input logic uns);
        logic [7:0]       b;
        logic [15:0]      h;
        logic [WIDTH-1:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{(WIDTH-8){~uns & b[7]}}, b};
            2'b01:   r = {{(WIDTH-16){~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane(s) of the word read back from memory.
    function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] old,
                                                     input logic [15:0] data,
                                                     input logic [1:0] size,
                                                     input logic [1:0] off);
        logic [WIDTH-1:0] r;
        r = old;
        if (size == 2'b00) begin
            case (off)
                2'b00:   r[7:0]   = data[7:0];
                2'b01:   r[15:8]  = data[7:0];
                2'b10:   r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end else if (off[1]) begin
            r[31:16] = data;
        end else begin
            r[15:0] = data;
        end
        return r;
    endfunction

    assign accept_s = (state_r == S_IDLE) && req_valid;
    assign bad_s    = req_bad(req_size, req_addr[1:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    if (bad_s) begin
                        state_nxt_s = S_RESP;
                    end else if (!req_we) begin
                        state_nxt_s = S_RD;
                    end else if (req_size == 2'b10) begin
                        state_nxt_s = S_WR;
                    end else begin
                        state_nxt_s = S_RMW_RD;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RD:     state_nxt_s = S_RESP;
            S_WR:     state_nxt_s = S_RESP;
            S_RMW_RD: state_nxt_s = S_RMW_WR;
            S_RMW_WR: state_nxt_s = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Request latches, memory-side outputs and response registers; strobes are
    // decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            size_r       <= 2'b00;
            off_r        <= 2'b00;
            uns_r        <= 1'b0;
            wdata_r      <= 16'h0000;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {WIDTH{1'b0}};
            resp_err_r   <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            address_r    <= {DEPTH{1'b0}};
            wd_r         <= {WIDTH{1'b0}};
        end else begin
            req_ready_r  <= (state_nxt_s == S_IDLE);
            resp_valid_r <= (state_nxt_s == S_RESP);
            mem_read_r   <= (state_nxt_s == S_RD) || (state_nxt_s == S_RMW_RD);
            mem_write_r  <= (state_nxt_s == S_WR) || (state_nxt_s == S_RMW_WR);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        size_r     <= req_size;
                        off_r      <= req_addr[1:0];
                        uns_r      <= req_unsigned;
                        wdata_r    <= req_wdata[15:0];
                        resp_err_r <= bad_s;
                        resp_rdata_r <= {WIDTH{1'b0}};
                        if (!bad_s) begin
                            address_r <= req_addr[DEPTH+1:2];
                        end
                        if (!bad_s && req_we && (req_size == 2'b10)) begin
                            wd_r <= req_wdata;
                        end
                    end
                end
                S_RD: begin
                    resp_rdata_r <= load_extend(RD, size_r, off_r, uns_r);
                    resp_err_r   <= 1'b0;
                end
                S_RMW_RD: begin
                    wd_r <= store_merge(RD, wdata_r, size_r, off_r);
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_rdata_r <= {WIDTH{1'b0}};
                        resp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    resp_err_r <= resp_err_r;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign MemRead    = mem_read_r;
    assign MemWrite   = mem_write_r;
    assign Address    = address_r;
    assign WD         = wd_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a negedge-read,
// posedge-write word memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [17:0] req_addr = 18'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] Address;
    logic [31:0] WD;
    logic [31:0] RD = 32'h0;

    logic [31:0] mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [15:0] last_waddr = 16'h0;
    logic [31:0] last_wd = 32'h0;

    mem_access_unit #(.WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WD(WD), .RD(RD)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    end

    always @(negedge clk) begin
        if (MemRead) RD <= mem[Address];
    end

    always @(posedge clk) begin
        if (MemWrite) begin
            mem[Address] <= WD;
            wr_cnt++;
            last_waddr <= Address;
            last_wd <= WD;
        end
        if (MemRead) rd_cnt++;
        if (MemRead && MemWrite) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [17:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        check("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rdata = resp_rdata;
        err = resp_err;
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [17:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_rd, input int exp_wr);
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          rd0;
        int          wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_req(we, size, uns, addr, wdata, lat, rdata, err);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_reads"}, rd_cnt - rd0, exp_rd);
        check({tag, "_writes"}, wr_cnt - wr0, exp_wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          wr0;
        logic [31:0] held;
        repeat (3) @(negedge clk);
        check("rst_memread", {31'd0, MemRead}, 32'd0);
        check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("rst_address", {16'd0, Address}, 32'd0);
        check("rst_wd", WD, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // word store / load
        run("st_word", 1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
        check("st_word_addr", {16'd0, last_waddr}, 32'h4);
        check("st_word_wd", last_wd, 32'hDEADBEEF);
        run("ld_word", 1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0);

        // extension cases on 0x80FF7F01
        run("st_word2", 1'b1, 2'b10, 1'b0, 18'h00010, 32'h80FF7F01, 2, 32'h0, 1'b0, 0, 1);
        run("ld_sb13", 1'b0, 2'b00, 1'b0, 18'h00013, 32'h0, 2, 32'hFFFFFF80, 1'b0, 1, 0);
        run("ld_ub13", 1'b0, 2'b00, 1'b1, 18'h00013, 32'h0, 2, 32'h00000080, 1'b0, 1, 0);
        run("ld_sh10", 1'b0, 2'b01, 1'b0, 18'h00010, 32'h0, 2, 32'h00007F01, 1'b0, 1, 0);
        run("ld_sh12", 1'b0, 2'b01, 1'b0, 18'h00012, 32'h0, 2, 32'hFFFF80FF, 1'b0, 1, 0);
        run("ld_uh12", 1'b0, 2'b01, 1'b1, 18'h00012, 32'h0, 2, 32'h000080FF, 1'b0, 1, 0);
        run("ld_sb11", 1'b0, 2'b00, 1'b0, 18'h00011, 32'h0, 2, 32'h0000007F, 1'b0, 1, 0);
        run("ld_ub10", 1'b0, 2'b00, 1'b1, 18'h00010, 32'h0, 2, 32'h00000001, 1'b0, 1, 0);

        // sub-word read-modify-write
        run("st_word3", 1'b1, 2'b10, 1'b0, 18'h00010, 32'h11223344, 2, 32'h0, 1'b0, 0, 1);
        run("st_b11", 1'b1, 2'b00, 1'b0, 18'h00011, 32'h000000AA, 3, 32'h0, 1'b0, 1, 1);
        check("st_b11_wd", last_wd, 32'h1122AA44);
        check("st_b11_mem", mem[4], 32'h1122AA44);
        run("st_h12", 1'b1, 2'b01, 1'b0, 18'h00012, 32'h1234BEEF, 3, 32'h0, 1'b0, 1, 1);
        run("ld_rmw", 1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 2, 32'hBEEFAA44, 1'b0, 1, 0);

        // error requests
        run("err_h11", 1'b0, 2'b01, 1'b0, 18'h00011, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        run("err_w12", 1'b1, 2'b10, 1'b0, 18'h00012, 32'h55555555, 1, 32'h0, 1'b1, 0, 0);
        run("err_sz3", 1'b0, 2'b11, 1'b0, 18'h00010, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        check("err_mem_kept", mem[4], 32'hBEEFAA44);

        // backpressure
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 18'h00010;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
        check("bp_valid", {31'd0, resp_valid}, 32'd1);
        held = resp_rdata;
        check("bp_data", held, 32'hBEEFAA44);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_hold_data", resp_rdata, 32'hBEEFAA44);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            check("bp_no_mem", {30'd0, MemRead, MemWrite}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_release_ready", {31'd0, req_ready}, 32'd1);

        // reset during RMW_RD
        run("st_word5", 1'b1, 2'b10, 1'b0, 18'h00014, 32'h55667788, 2, 32'h0, 1'b0, 0, 1);
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 18'h00015;
        req_wdata = 32'h000000CC;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_rst_in_rd", {31'd0, MemRead}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rmw_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("rmw_rst_memread", {31'd0, MemRead}, 32'd0);
        check("rmw_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rmw_rst_address", {16'd0, Address}, 32'd0);
        check("rmw_rst_wd", WD, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("rmw_rst_no_write", wr_cnt - wr0, 32'd0);
        check("rmw_rst_mem", mem[5], 32'h55667788);
        run("ld_after_rst", 1'b0, 2'b10, 1'b0, 18'h00014, 32'h0, 2, 32'h55667788, 1'b0, 1, 0);

        check("never_both", both_cnt, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
